// File: rtl/reg_file_2r1w_pkg.sv
// Shared types and helpers for the two-read/one-write register file:
// clear-engine state encoding, byte-count constants and the byte-merge function.
package reg_file_2r1w_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned RF_DATA_WIDTH = 16;
  localparam int unsigned RF_NUM_BYTES  = RF_DATA_WIDTH / 8;

  // Merge operates on a wide container so any DATA_WIDTH up to 128 can reuse it.
  localparam int unsigned RF_MAX_WIDTH  = 128;
  localparam int unsigned RF_MAX_BYTES  = RF_MAX_WIDTH / 8;

  function automatic logic [RF_MAX_WIDTH-1:0] merge_bytes(
    input logic [RF_MAX_WIDTH-1:0] old_word,
    input logic [RF_MAX_WIDTH-1:0] new_word,
    input logic [RF_MAX_BYTES-1:0] mask
  );
    logic [RF_MAX_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < int'(RF_MAX_BYTES); k++) begin
      if (mask[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// Bulk-clear engine: walks entries 0..DEPTH-1 once per request, holding Busy
// for exactly DEPTH cycles and presenting one clear write per cycle.
module reg_file_clr_ctrl
  import reg_file_2r1w_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // Requests arriving here are ignored; the walk always runs to the end.
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with byte-masked writes, registered reads,
// address-range error flag and a sequential bulk clear.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WrEn,
  input  logic [ADDR_WIDTH-1:0]   WrAddr,
  input  logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH/8-1:0] WrMask,
  input  logic                    RdEnA,
  input  logic [ADDR_WIDTH-1:0]   RdAddrA,
  input  logic                    RdEnB,
  input  logic [ADDR_WIDTH-1:0]   RdAddrB,
  output logic [DATA_WIDTH-1:0]   RdDataA,
  output logic [DATA_WIDTH-1:0]   RdDataB,
  output logic                    RdValidA,
  output logic                    RdValidB,
  input  logic                    ClrReq,
  output logic                    Busy,
  output logic                    AddrErr
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned AW1       = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] DEPTH_LIM = AW1'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_BYTES-1:0]  mask
  );
    return DATA_WIDTH'(merge_bytes(RF_MAX_WIDTH'(old_word), RF_MAX_WIDTH'(new_word),
                                   RF_MAX_BYTES'(mask)));
  endfunction

  logic                  busy, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  reg_file_clr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clr_ctrl (
    .clk      (CLK),
    .rst_n    (RST),
    .clr_req  (ClrReq),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic                  rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
  logic                  addr_err_q, addr_err_d;

  logic                  wr_acc, rd_a_acc, rd_b_acc;
  logic                  wr_ok, rd_a_ok, rd_b_ok;
  logic [DATA_WIDTH-1:0] wr_word, rd_a_word, rd_b_word;

  // Request qualification: everything is dropped while the clear engine runs.
  always_comb begin
    wr_acc   = WrEn  && !busy;
    rd_a_acc = RdEnA && !busy;
    rd_b_acc = RdEnB && !busy;
    wr_ok    = {1'b0, WrAddr}  < DEPTH_LIM;
    rd_a_ok  = {1'b0, RdAddrA} < DEPTH_LIM;
    rd_b_ok  = {1'b0, RdAddrB} < DEPTH_LIM;
    wr_word  = merge_word(mem_q[WrAddr], WrData, WrMask);
`ifdef REG_FILE_BYPASS_EN
    rd_a_word = (wr_acc && wr_ok && (WrAddr == RdAddrA)) ? wr_word : mem_q[RdAddrA];
    rd_b_word = (wr_acc && wr_ok && (WrAddr == RdAddrB)) ? wr_word : mem_q[RdAddrB];
`else
    rd_a_word = mem_q[RdAddrA];
    rd_b_word = mem_q[RdAddrB];
`endif
  end

  // The clear engine owns the write port while busy; user writes cannot collide.
  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else if (wr_acc && wr_ok) begin
      mem_d[WrAddr] = wr_word;
    end
  end

  always_comb begin
    rd_data_a_d  = rd_data_a_q;
    rd_data_b_d  = rd_data_b_q;
    rd_valid_a_d = rd_a_acc;
    rd_valid_b_d = rd_b_acc;
    if (rd_a_acc) rd_data_a_d = rd_a_ok ? rd_a_word : '0;
    if (rd_b_acc) rd_data_b_d = rd_b_ok ? rd_b_word : '0;
    addr_err_d = (wr_acc && !wr_ok) || (rd_a_acc && !rd_a_ok) || (rd_b_acc && !rd_b_ok);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_q        <= '{default: '0};
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign RdDataA  = rd_data_a_q;
  assign RdDataB  = rd_data_b_q;
  assign RdValidA = rd_valid_a_q;
  assign RdValidB = rd_valid_b_q;
  assign Busy     = busy;
  assign AddrErr  = addr_err_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: a full-range instance (DEPTH 8) and a
// short instance (DEPTH 6) share one stimulus stream.
module tb_reg_file_2r1w;

  typedef struct packed {
    logic        va;
    logic        vb;
    logic        err;
    logic        busy;
    logic [15:0] da;
    logic [15:0] db;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [1:0]  wm;
    logic        ena;
    logic [2:0]  aa;
    logic        enb;
    logic [2:0]  ab;
    logic        clr;
  } stim_t;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        WrEn, RdEnA, RdEnB, ClrReq;
  logic [2:0]  WrAddr, RdAddrA, RdAddrB;
  logic [15:0] WrData;
  logic [1:0]  WrMask;

  logic [15:0] RdDataA8, RdDataB8, RdDataA6, RdDataB6;
  logic        RdValidA8, RdValidB8, Busy8, AddrErr8;
  logic        RdValidA6, RdValidB6, Busy6, AddrErr6;

  always #5 CLK = ~CLK;

  reg_file_2r1w #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .DEPTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrMask(WrMask),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
    .RdDataA(RdDataA8), .RdDataB(RdDataB8), .RdValidA(RdValidA8), .RdValidB(RdValidB8),
    .ClrReq(ClrReq), .Busy(Busy8), .AddrErr(AddrErr8)
  );

  reg_file_2r1w #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .DEPTH(6)) dut6 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrMask(WrMask),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
    .RdDataA(RdDataA6), .RdDataB(RdDataB6), .RdValidA(RdValidA6), .RdValidB(RdValidB6),
    .ClrReq(ClrReq), .Busy(Busy6), .AddrErr(AddrErr6)
  );

  exp_t got8, got6;
  assign got8 = {RdValidA8, RdValidB8, AddrErr8, Busy8, RdDataA8, RdDataB8};
  assign got6 = {RdValidA6, RdValidB6, AddrErr6, Busy6, RdDataA6, RdDataB6};

  int checks = 0;
  int errors = 0;

  exp_t q8[$];
  exp_t q6[$];

  // Reference state per instance: index 0 = DEPTH 8, index 1 = DEPTH 6.
  logic [15:0] mdl_mem [2][8];
  bit          mdl_busy [2];
  int          mdl_cnt [2];
  logic [15:0] mdl_la [2];
  logic [15:0] mdl_lb [2];

  function automatic logic [15:0] bmerge(input logic [15:0] o, input logic [15:0] n,
                                         input logic [1:0] m);
    logic [15:0] r;
    r = o;
    if (m[0]) r[7:0]  = n[7:0];
    if (m[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  function automatic stim_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                               input logic [1:0] wm, input logic ena, input logic [2:0] aa,
                               input logic enb, input logic [2:0] ab, input logic clr);
    stim_t s;
    s.we = we; s.wa = wa; s.wd = wd; s.wm = wm;
    s.ena = ena; s.aa = aa; s.enb = enb; s.ab = ab; s.clr = clr;
    return s;
  endfunction

  task automatic set_idle();
    WrEn = 1'b0; WrAddr = 3'd0; WrData = 16'h0; WrMask = 2'b00;
    RdEnA = 1'b0; RdAddrA = 3'd0; RdEnB = 1'b0; RdAddrB = 3'd0; ClrReq = 1'b0;
  endtask

  // Drives one cycle of stimulus, pushes each instance's expected outputs, and
  // returns 1 time unit after the rising edge.
  task automatic cycle(input stim_t s);
    exp_t        e;
    logic [15:0] mw;
    int          d;
    @(negedge CLK);
    WrEn = s.we; WrAddr = s.wa; WrData = s.wd; WrMask = s.wm;
    RdEnA = s.ena; RdAddrA = s.aa; RdEnB = s.enb; RdAddrB = s.ab; ClrReq = s.clr;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 8 : 6;
      e = '0;
      if (!mdl_busy[i]) begin
        mw = bmerge(mdl_mem[i][s.wa], s.wd, s.wm);
        if (s.ena) begin
          e.va = 1'b1;
          if (int'(s.aa) < d)
            mdl_la[i] = (BYP && s.we && int'(s.wa) < d && s.wa == s.aa) ? mw : mdl_mem[i][s.aa];
          else begin
            mdl_la[i] = 16'h0;
            e.err = 1'b1;
          end
        end
        if (s.enb) begin
          e.vb = 1'b1;
          if (int'(s.ab) < d)
            mdl_lb[i] = (BYP && s.we && int'(s.wa) < d && s.wa == s.ab) ? mw : mdl_mem[i][s.ab];
          else begin
            mdl_lb[i] = 16'h0;
            e.err = 1'b1;
          end
        end
        if (s.we) begin
          if (int'(s.wa) < d) mdl_mem[i][s.wa] = mw;
          else e.err = 1'b1;
        end
        if (s.clr) begin
          mdl_busy[i] = 1'b1;
          mdl_cnt[i]  = 0;
        end
      end else begin
        mdl_mem[i][mdl_cnt[i]] = 16'h0;
        if (mdl_cnt[i] == d - 1) mdl_busy[i] = 1'b0;
        else mdl_cnt[i]++;
      end
      e.da = mdl_la[i];
      e.db = mdl_lb[i];
      e.busy = mdl_busy[i];
      if (i == 0) q8.push_back(e);
      else q6.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic assert_reset();
    @(negedge CLK);
    set_idle();
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 8; a++) mdl_mem[i][a] = 16'h0;
      mdl_busy[i] = 1'b0;
      mdl_cnt[i]  = 0;
      mdl_la[i]   = 16'h0;
      mdl_lb[i]   = 16'h0;
    end
    q8.delete();
    q6.delete();
    #1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    stim_t rows[$];
    exp_t  e;
    assert_reset();
    checks++;
    if (got8 !== '0 || got6 !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h / %h, need 0", got8, got6);
    end
    release_reset();
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd0, 1'b1, 3'd7, 1'b0));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    foreach (rows[r]) begin
      cycle(rows[r]);
      e = q8.pop_front(); checks++;
      if (got8 !== e) begin errors++; $display("FAIL reset_read_d8 row %0d: got %h need %h", r, got8, e); end
      e = q6.pop_front(); checks++;
      if (got6 !== e) begin errors++; $display("FAIL reset_read_d6 row %0d: got %h need %h", r, got6, e); end
    end
  endtask

  task automatic test_masked_write();
    stim_t rows[$];
    exp_t  e;
    rows.push_back(mk(1'b1, 3'd3, 16'hABCD, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b1, 3'd3, 16'h1200, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b1, 3'd4, 16'h7777, 2'b00, 1'b1, 3'd3, 1'b1, 3'd4, 1'b0));
    rows.push_back(mk(1'b1, 3'd4, 16'h0056, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd4, 1'b1, 3'd3, 1'b0));
    foreach (rows[r]) begin
      cycle(rows[r]);
      e = q8.pop_front(); checks++;
      if (got8 !== e) begin errors++; $display("FAIL masked_d8 row %0d: got %h need %h", r, got8, e); end
      e = q6.pop_front(); checks++;
      if (got6 !== e) begin errors++; $display("FAIL masked_d6 row %0d: got %h need %h", r, got6, e); end
    end
  endtask

  task automatic test_bypass();
    stim_t rows[$];
    exp_t  e;
    rows.push_back(mk(1'b1, 3'd5, 16'h1111, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b1, 3'd5, 16'h5555, 2'b11, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0));
    rows.push_back(mk(1'b1, 3'd5, 16'h9900, 2'b10, 1'b1, 3'd5, 1'b1, 3'd3, 1'b0));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0));
    foreach (rows[r]) begin
      cycle(rows[r]);
      e = q8.pop_front(); checks++;
      if (got8 !== e) begin errors++; $display("FAIL bypass_d8 row %0d: got %h need %h", r, got8, e); end
      e = q6.pop_front(); checks++;
      if (got6 !== e) begin errors++; $display("FAIL bypass_d6 row %0d: got %h need %h", r, got6, e); end
    end
  endtask

  task automatic test_out_of_range();
    stim_t rows[$];
    exp_t  e;
    rows.push_back(mk(1'b1, 3'd6, 16'hFFFF, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    for (int a = 0; a < 6; a += 2)
      rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(a), 1'b1, 3'(a + 1), 1'b0));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    foreach (rows[r]) begin
      cycle(rows[r]);
      e = q8.pop_front(); checks++;
      if (got8 !== e) begin errors++; $display("FAIL oor_d8 row %0d: got %h need %h", r, got8, e); end
      e = q6.pop_front(); checks++;
      if (got6 !== e) begin errors++; $display("FAIL oor_d6 row %0d: got %h need %h", r, got6, e); end
    end
  endtask

  task automatic test_clear();
    stim_t rows[$];
    exp_t  e;
    int    busy_cycles;
    busy_cycles = 0;
    for (int a = 0; a < 8; a++)
      rows.push_back(mk(1'b1, 3'(a), 16'(16'h1111 * (a + 1)), 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b1, 3'd2, 16'hBEEF, 2'b11, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1));
    for (int k = 0; k < 6; k++)
      rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    for (int a = 0; a < 8; a += 2)
      rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(a), 1'b1, 3'(a + 1), 1'b0));
    foreach (rows[r]) begin
      cycle(rows[r]);
      if (Busy8) busy_cycles++;
      e = q8.pop_front(); checks++;
      if (got8 !== e) begin errors++; $display("FAIL clear_d8 row %0d: got %h need %h", r, got8, e); end
      e = q6.pop_front(); checks++;
      if (got6 !== e) begin errors++; $display("FAIL clear_d6 row %0d: got %h need %h", r, got6, e); end
    end
    checks++;
    if (busy_cycles != 8) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d cycles, need 8", busy_cycles);
    end
  endtask

  task automatic test_reset_mid_clear();
    stim_t rows[$];
    stim_t post[$];
    exp_t  e;
    rows.push_back(mk(1'b1, 3'd4, 16'h4242, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b1, 3'd1, 16'hABCD, 2'b11, 1'b1, 3'd4, 1'b0, 3'd0, 1'b1));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    rows.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0));
    foreach (rows[r]) begin
      cycle(rows[r]);
      e = q8.pop_front(); checks++;
      if (got8 !== e) begin errors++; $display("FAIL midclr_d8 row %0d: got %h need %h", r, got8, e); end
      e = q6.pop_front(); checks++;
      if (got6 !== e) begin errors++; $display("FAIL midclr_d6 row %0d: got %h need %h", r, got6, e); end
    end
    assert_reset();
    checks++;
    if (got8 !== '0 || got6 !== '0) begin
      errors++;
      $display("FAIL midclr_async_reset: got %h / %h, need 0", got8, got6);
    end
    release_reset();
    for (int a = 0; a < 8; a += 2)
      post.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(a), 1'b1, 3'(a + 1), 1'b0));
    foreach (post[r]) begin
      cycle(post[r]);
      e = q8.pop_front(); checks++;
      if (got8 !== e) begin errors++; $display("FAIL postrst_d8 row %0d: got %h need %h", r, got8, e); end
      e = q6.pop_front(); checks++;
      if (got6 !== e) begin errors++; $display("FAIL postrst_d6 row %0d: got %h need %h", r, got6, e); end
    end
  endtask

  initial begin
    RST = 1'b0;
    set_idle();
    test_reset();
    test_masked_write();
    test_bypass();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, need completion", $time);
    $fatal(1, "bench timeout");
  end

endmodule
